// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, alu_ctrl opcode encoding and the
// sharing-controller state encoding.
package alu_pkg;

   localparam int CTRL_W = 4;

   localparam logic [CTRL_W-1:0] ALU_AND  = 4'd0;
   localparam logic [CTRL_W-1:0] ALU_OR   = 4'd1;
   localparam logic [CTRL_W-1:0] ALU_ADD  = 4'd2;
   localparam logic [CTRL_W-1:0] ALU_SUB  = 4'd3;
   localparam logic [CTRL_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [CTRL_W-1:0] ALU_BEQ  = 4'd5;
   localparam logic [CTRL_W-1:0] ALU_BNE  = 4'd6;
   localparam logic [CTRL_W-1:0] ALU_BLT  = 4'd7;
   localparam logic [CTRL_W-1:0] ALU_BGE  = 4'd8;
   localparam logic [CTRL_W-1:0] ALU_BLTU = 4'd9;
   localparam logic [CTRL_W-1:0] ALU_BGEU = 4'd10;
   localparam logic [CTRL_W-1:0] ALU_SLL  = 4'd11;
   localparam logic [CTRL_W-1:0] ALU_SRL  = 4'd12;
   localparam logic [CTRL_W-1:0] ALU_SRA  = 4'd13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_share_arb2.sv
// Two-way grant for the shared ALU. Round-robin on ties by default; define
// ALU_SHARE_FIXED_PRIO_EN to make req0 always win a tie.
module alu_share_arb2 (
`ifndef ALU_SHARE_FIXED_PRIO_EN
   input  logic clk,
   input  logic rst,
   input  logic accept,
`endif
   input  logic req0_valid,
   input  logic req1_valid,
   output logic grant_valid,
   output logic grant
);

`ifdef ALU_SHARE_FIXED_PRIO_EN
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant       = ~req0_valid & req1_valid;
   end
`else
   logic last_grant;

   // Reset value 1 lets req0 win the first tie.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant;
   end

   always_comb begin
      grant_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else
         grant = req1_valid;
   end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between execute (req0) and branch (req1) requesters.
// Tie policy is round-robin unless ALU_SHARE_FIXED_PRIO_EN is defined.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = alu_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [XLEN-1:0]   req0_a,
   input  logic [XLEN-1:0]   req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [XLEN-1:0]   req1_a,
   input  logic [XLEN-1:0]   req1_b,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [XLEN-1:0]   resp_result,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   input  logic [XLEN-1:0]   alu_result,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              owner_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [XLEN-1:0]   a_q, b_q, result_q;
   logic              grant_valid, grant, accept;

   alu_share_arb2 u_arb (
`ifndef ALU_SHARE_FIXED_PRIO_EN
      .clk        (clk),
      .rst        (rst),
      .accept     (accept),
`endif
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .grant_valid(grant_valid),
      .grant      (grant)
   );

   // Gated by rst so no handshake completes while the block is being reset.
   assign accept      = (state_q == IDLE) && grant_valid && !rst;
   assign busy        = (state_q != IDLE);
   assign resp_result = result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            owner_q <= grant;
         if (state_q == EXEC)
            result_q <= alu_result;
      end
   end

   // NOTE: operand regs carry no reset; the ALU drive is zeroed outside EXEC, so stale contents never escape.
   always_ff @(posedge clk) begin
      if (accept) begin
         ctrl_q <= grant ? req1_ctrl : req0_ctrl;
         a_q    <= grant ? req1_a    : req0_a;
         b_q    <= grant ? req1_b    : req0_b;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (owner_q ? resp1_ready : resp0_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      alu_ctrl    = '0;
      alu_a       = '0;
      alu_b       = '0;
      case (state_q)
         IDLE: begin
            req0_ready = accept & ~grant;
            req1_ready = accept &  grant;
         end
         EXEC: begin
            alu_ctrl = ctrl_q;
            alu_a    = a_q;
            alu_b    = b_q;
         end
         RESP: begin
            resp0_valid = ~owner_q;
            resp1_valid =  owner_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl; a small ALU model closes the loop.
// Grant-order expectations follow ALU_SHARE_FIXED_PRIO_EN when it is defined.
module tb_alu_share_ctrl;
   import alu_pkg::*;

   localparam int XLEN = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [CTRL_W-1:0] req0_ctrl, req1_ctrl, alu_ctrl;
   logic [XLEN-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic              resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [XLEN-1:0]   resp_result, alu_a, alu_b, alu_result;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   alu_share_ctrl #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_ctrl  (req0_ctrl),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_ctrl  (req1_ctrl),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .resp0_valid(resp0_valid),
      .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid),
      .resp1_ready(resp1_ready),
      .resp_result(resp_result),
      .alu_ctrl   (alu_ctrl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference combinational ALU feeding the DUT.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_AND:  alu_result = alu_a & alu_b;
         ALU_OR:   alu_result = alu_a | alu_b;
         ALU_ADD:  alu_result = alu_a + alu_b;
         ALU_SUB:  alu_result = alu_a - alu_b;
         ALU_XOR:  alu_result = alu_a ^ alu_b;
         ALU_BEQ:  alu_result = {31'd0, alu_a == alu_b};
         ALU_BNE:  alu_result = {31'd0, alu_a != alu_b};
         ALU_BLT:  alu_result = {31'd0, $signed(alu_a) <  $signed(alu_b)};
         ALU_BGE:  alu_result = {31'd0, $signed(alu_a) >= $signed(alu_b)};
         ALU_BLTU: alu_result = {31'd0, alu_a <  alu_b};
         ALU_BGEU: alu_result = {31'd0, alu_a >= alu_b};
         ALU_SLL:  alu_result = alu_a << alu_b[4:0];
         ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_result = $signed(alu_a) >>> alu_b[4:0];
         default:  alu_result = '0;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid  = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0;
      req1_valid  = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
      checks++; if ({resp1_valid, resp0_valid} !== 2'b00) begin failures++; $display("FAIL reset_resp_valid: got %b want 00", {resp1_valid, resp0_valid}); end
      checks++; if (resp_result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h want 0", resp_result); end
      checks++; if ({alu_ctrl, alu_a, alu_b} !== '0) begin failures++; $display("FAIL reset_alu_zero: got %h/%h/%h want 0", alu_ctrl, alu_a, alu_b); end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_single_req0();
      req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7;
      resp0_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_req0_ready: got %b want 1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_exec: got %b want 1", busy); end
      checks++; if ({alu_ctrl, alu_a, alu_b} !== {ALU_ADD, 32'd5, 32'd7}) begin failures++; $display("FAIL single_alu_drive: got %h/%h/%h want 2/5/7", alu_ctrl, alu_a, alu_b); end
      checks++; if (resp0_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", resp0_valid); end
      tick();
      #1;
      checks++; if ({resp1_valid, resp0_valid} !== 2'b01) begin failures++; $display("FAIL single_resp_valid: got %b want 01", {resp1_valid, resp0_valid}); end
      checks++; if (resp_result !== 32'd12) begin failures++; $display("FAIL single_result: got %0d want 12", resp_result); end
      checks++; if ({alu_ctrl, alu_a, alu_b} !== '0) begin failures++; $display("FAIL single_alu_zero_resp: got %h/%h/%h want 0", alu_ctrl, alu_a, alu_b); end
      tick();
      #1;
      checks++; if ({busy, resp0_valid} !== 2'b00) begin failures++; $display("FAIL single_retire: got busy=%b valid=%b want 0 0", busy, resp0_valid); end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_grants;
      logic       g;
      int         waited;
`ifdef ALU_SHARE_FIXED_PRIO_EN
      exp_grants = 4'b0000;
`else
      exp_grants = 4'b1010;
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd10;         req0_b = 32'd20;
      req1_valid = 1'b1; req1_ctrl = ALU_BLT; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         waited = 0;
         while (!(req0_ready | req1_ready) && waited < 6) begin
            tick();
            #1;
            waited++;
         end
         checks++;
         if (!(req0_ready | req1_ready)) begin
            failures++; $display("FAIL b2b_timeout: grant %0d never issued", k);
         end else begin
            g = req1_ready;
            checks++; if (g !== exp_grants[k]) begin failures++; $display("FAIL b2b_grant%0d: got %b want %b", k, g, exp_grants[k]); end
            checks++; if (waited !== 0) begin failures++; $display("FAIL b2b_interval%0d: got %0d idle waits want 0", k, waited); end
            tick();
            tick();
            #1;
            checks++; if ({resp1_valid, resp0_valid} !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_resp_valid%0d: got %b", k, {resp1_valid, resp0_valid}); end
            checks++; if (resp_result !== (g ? 32'd1 : 32'd30)) begin failures++; $display("FAIL b2b_result%0d: got %0d want %0d", k, resp_result, g ? 1 : 30); end
            tick();
            #1;
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_backpressure();
      req1_valid = 1'b1; req1_ctrl = ALU_BEQ; req1_a = 32'd3; req1_b = 32'd3;
      #1;
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_req1_ready: got %b want 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
      #1;
      checks++; if ({req0_ready, alu_ctrl} !== {1'b0, ALU_BEQ}) begin failures++; $display("FAIL bp_exec: got ready=%b ctrl=%0d want 0 5", req0_ready, alu_ctrl); end
      tick();
      for (int i = 0; i < 4; i++) begin
         resp0_ready = i[0];
         #1;
         checks++; if ({resp1_valid, resp0_valid} !== 2'b10) begin failures++; $display("FAIL bp_hold_valid%0d: got %b want 10", i, {resp1_valid, resp0_valid}); end
         checks++; if (resp_result !== 32'd1) begin failures++; $display("FAIL bp_hold_result%0d: got %h want 1", i, resp_result); end
         checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_no_grant%0d: got %b want 0", i, req0_ready); end
         tick();
      end
      resp0_ready = 1'b0;
      resp1_ready = 1'b1;
      #1;
      checks++; if ({resp1_valid, req0_ready} !== 2'b10) begin failures++; $display("FAIL bp_retire_cycle: got valid=%b ready=%b want 1 0", resp1_valid, req0_ready); end
      tick();
      resp1_ready = 1'b0;
      #1;
      checks++; if ({resp1_valid, req0_ready} !== 2'b01) begin failures++; $display("FAIL bp_after_retire: got valid=%b ready=%b want 0 1", resp1_valid, req0_ready); end
      tick();
      req0_valid  = 1'b0;
      resp0_ready = 1'b1;
      tick();
      #1;
      checks++; if ({resp0_valid, resp_result} !== {1'b1, 32'd3}) begin failures++; $display("FAIL bp_req0_result: got valid=%b result=%0d want 1 3", resp0_valid, resp_result); end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_in_exec();
      logic seen;
      req0_valid = 1'b1; req0_ctrl = ALU_SUB; req0_a = 32'd9; req0_b = 32'd4;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rexec_ready: got %b want 1", req0_ready); end
      tick();
      idle_inputs();
      resp0_ready = 1'b1;
      #1;
      checks++; if (alu_ctrl !== ALU_SUB) begin failures++; $display("FAIL rexec_in_exec: got %0d want 3", alu_ctrl); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if ({busy, alu_ctrl, alu_a, alu_b} !== '0) begin failures++; $display("FAIL rexec_flushed: got busy=%b ctrl=%0d", busy, alu_ctrl); end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen = seen | resp0_valid;
         tick();
         #1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rexec_no_resp: got resp0_valid=%b want 0", seen); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_resp();
      req1_valid = 1'b1; req1_ctrl = ALU_BNE; req1_a = 32'd1; req1_b = 32'd2;
      #1;
      tick();
      req1_valid = 1'b0;
      tick();
      #1;
      checks++; if ({resp1_valid, resp_result} !== {1'b1, 32'd1}) begin failures++; $display("FAIL rresp_pre: got valid=%b result=%h want 1 1", resp1_valid, resp_result); end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++; if ({busy, resp1_valid, resp0_valid} !== 3'b000) begin failures++; $display("FAIL rresp_state: got %b want 000", {busy, resp1_valid, resp0_valid}); end
      checks++; if ({resp_result, alu_ctrl, alu_a, alu_b} !== '0) begin failures++; $display("FAIL rresp_zero: got result=%h ctrl=%0d", resp_result, alu_ctrl); end
      tick();
      #1;
      checks++; if (resp1_valid !== 1'b0) begin failures++; $display("FAIL rresp_discarded: got %b want 0", resp1_valid); end
      idle_inputs();
   endtask

   task automatic test_drop_valid();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_ctrl = ALU_XOR; req0_a = 32'hF0;  req0_b = 32'hFF;
      req1_valid = 1'b1; req1_ctrl = ALU_SUB; req1_a = 32'd100; req1_b = 32'd1;
      resp0_ready = 1'b1;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL drop_grant: got %b want 01", {req1_ready, req0_ready}); end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      checks++; if ({alu_ctrl, alu_a} !== {ALU_XOR, 32'hF0}) begin failures++; $display("FAIL drop_exec: got %0d/%h want 4/f0", alu_ctrl, alu_a); end
      tick();
      #1;
      checks++; if ({resp0_valid, resp_result} !== {1'b1, 32'h0F}) begin failures++; $display("FAIL drop_req0_result: got valid=%b result=%h", resp0_valid, resp_result); end
      tick();
      tick();
      #1;
      checks++; if ({busy, resp1_valid} !== 2'b00) begin failures++; $display("FAIL drop_no_latch: got busy=%b valid=%b want 0 0", busy, resp1_valid); end
      req1_valid = 1'b1; req1_ctrl = ALU_SRL; req1_a = 32'h80; req1_b = 32'd3;
      resp1_ready = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL drop_srl_ready: got %b want 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      #1;
      checks++; if ({alu_ctrl, alu_a, alu_b} !== {ALU_SRL, 32'h80, 32'd3}) begin failures++; $display("FAIL drop_srl_drive: got %0d/%h/%h", alu_ctrl, alu_a, alu_b); end
      tick();
      #1;
      checks++; if ({resp1_valid, resp_result} !== {1'b1, 32'h10}) begin failures++; $display("FAIL drop_srl_result: got valid=%b result=%h want 1 10", resp1_valid, resp_result); end
      tick();
      idle_inputs();
   endtask

   task automatic test_opcode_passthrough();
      logic [CTRL_W-1:0] op;
      op = 4'd14;
      req0_valid = 1'b1; req0_ctrl = op; req0_a = 32'd1; req0_b = 32'd1;
      resp0_ready = 1'b1;
      #1;
      tick();
      req0_valid = 1'b0;
      #1;
      checks++; if (alu_ctrl !== op) begin failures++; $display("FAIL op14_forward: got %0d want 14", alu_ctrl); end
      tick();
      #1;
      checks++; if ({resp0_valid, resp_result} !== {1'b1, 32'd0}) begin failures++; $display("FAIL op14_result: got valid=%b result=%h want 1 0", resp0_valid, resp_result); end
      tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_single_req0();
      test_back_to_back();
      test_backpressure();
      test_reset_in_exec();
      test_reset_mid_resp();
      test_drop_valid();
      test_opcode_passthrough();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
